// File: rtl/xgcd_pkg.sv
// Shared types and constants for the XGCD operand-loading path.
package xgcd_pkg;

  localparam int XGCD_WORD_W = 64;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_FIN  = 3'd4
  } loader_state_t;

endpackage

// File: rtl/xgcd_axi_operand_loader.sv
// AXI4 write-burst master that streams NUM_WORDS operand words into an XGCD core.
//
// state | meaning
// IDLE  | waiting for START
// AW    | write address presented, waiting for AWREADY
// W     | stream words passed through to the W channel
// B     | waiting for the write response of the current burst
// FIN   | job complete, DONE registered for the next cycle
module xgcd_axi_operand_loader
  import xgcd_pkg::*;
#(
  parameter int         NUM_WORDS = 4,
  parameter int         BURST_LEN = 16,
  parameter logic [3:0] AXI_ID    = 4'h0
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  input  logic                   START,
  input  logic [31:0]            DST_ADDR,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERR,
  input  logic [XGCD_WORD_W-1:0] S_DATA,
  input  logic                   S_VALID,
  output logic                   S_READY,
  output logic [3:0]             AWID,
  output logic [31:0]            AWADDR,
  output logic [7:0]             AWLEN,
  output logic [2:0]             AWSIZE,
  output logic [1:0]             AWBURST,
  output logic                   AWLOCK,
  output logic [3:0]             AWCACHE,
  output logic [2:0]             AWPROT,
  output logic                   AWVALID,
  input  logic                   AWREADY,
  output logic [XGCD_WORD_W-1:0] WDATA,
  output logic [7:0]             WSTRB,
  output logic                   WLAST,
  output logic                   WVALID,
  input  logic                   WREADY,
  input  logic [3:0]             BID,
  input  logic [1:0]             BRESP,
  input  logic                   BVALID,
  output logic                   BREADY
);

  localparam int CW = $clog2(NUM_WORDS + 1);

  loader_state_t state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [7:0]    awlen_q, awlen_d;
  logic          awvalid_q, awvalid_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [CW-1:0] beat_q, beat_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          beat_fire;
  logic          last_beat;

  // AWLEN for the next burst: the smaller of BURST_LEN and what is left, minus one.
  function automatic logic [7:0] next_awlen(input logic [CW-1:0] rem);
    if (int'(rem) >= BURST_LEN) return 8'(BURST_LEN - 1);
    return 8'(int'(rem) - 1);
  endfunction

  // The AWLEN register doubles as the latched burst length for the W phase.
  assign beat_fire = (state_q == ST_W) && S_VALID && WREADY;
  assign last_beat = (state_q == ST_W) && (beat_q == CW'(awlen_q));

  // Next-state and datapath updates for the job sequencer.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    awlen_d   = awlen_q;
    awvalid_d = awvalid_q;
    rem_d     = rem_q;
    beat_d    = beat_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;

    if (done_q) busy_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          busy_d = 1'b1;
          if (DST_ADDR[2:0] == 3'b000) begin
            err_d     = 1'b0;
            addr_d    = DST_ADDR;
            rem_d     = CW'(NUM_WORDS);
            awlen_d   = next_awlen(CW'(NUM_WORDS));
            awvalid_d = 1'b1;
            state_d   = ST_AW;
          end else begin
            err_d   = 1'b1;
            state_d = ST_FIN;
          end
        end
      end
      ST_AW: begin
        if (AWREADY) begin
          awvalid_d = 1'b0;
          beat_d    = '0;
          state_d   = ST_W;
        end
      end
      ST_W: begin
        if (beat_fire) begin
          if (last_beat) begin
            addr_d  = addr_q + ((32'(awlen_q) + 32'd1) << 3);
            rem_d   = rem_q - CW'(awlen_q) - CW'(1);
            state_d = ST_B;
          end else begin
            beat_d = beat_q + CW'(1);
          end
        end
      end
      ST_B: begin
        if (BVALID) begin
          // A bad response is recorded but the job still drains every word.
          if ((BRESP != AXI_RESP_OKAY) || (BID != AXI_ID)) err_d = 1'b1;
          if (rem_q != '0) begin
            awlen_d   = next_awlen(rem_q);
            awvalid_d = 1'b1;
            state_d   = ST_AW;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops every valid and clears ERR.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      awlen_q   <= '0;
      awvalid_q <= 1'b0;
      rem_q     <= '0;
      beat_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      awlen_q   <= awlen_d;
      awvalid_q <= awvalid_d;
      rem_q     <= rem_d;
      beat_q    <= beat_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ERR     = err_q;

  assign AWID    = AXI_ID;
  assign AWADDR  = addr_q;
  assign AWLEN   = awlen_q;
  assign AWSIZE  = AXI_SIZE_8B;
  assign AWBURST = AXI_BURST_INCR;
  assign AWLOCK  = 1'b0;
  assign AWCACHE = 4'd0;
  assign AWPROT  = 3'd0;
  assign AWVALID = awvalid_q;

  // W channel is a direct pass-through of the operand stream while in W.
  assign WVALID  = (state_q == ST_W) && S_VALID;
  assign S_READY = (state_q == ST_W) && WREADY;
  assign WDATA   = S_DATA;
  assign WSTRB   = 8'hFF;
  assign WLAST   = last_beat;

  assign BREADY  = (state_q == ST_B);

endmodule

// File: tb/tb_xgcd_axi_operand_loader.sv
// Scoreboard bench: two loader instances (4-word and 20-word) share one AXI slave model.
`timescale 1ns/1ps
module tb_xgcd_axi_operand_loader;

  localparam logic [3:0] ID0 = 4'h0;
  localparam logic [3:0] ID1 = 4'h5;
  localparam int         BL  = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]  start;
  logic [31:0] dst_addr;
  logic [1:0]  busy, done, err, awvalid, awlock, wvalid, wlast, bready, s_ready;
  logic [3:0]  awid    [2];
  logic [31:0] awaddr  [2];
  logic [7:0]  awlen   [2];
  logic [2:0]  awsize  [2];
  logic [1:0]  awburst [2];
  logic [3:0]  awcache [2];
  logic [2:0]  awprot  [2];
  logic [63:0] wdata   [2];
  logic [7:0]  wstrb   [2];

  logic [63:0] s_data;
  logic        s_valid, awready, wready, bvalid;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    xgcd_axi_operand_loader #(
      .NUM_WORDS ((g == 0) ? 4 : 20),
      .BURST_LEN (BL),
      .AXI_ID    ((g == 0) ? ID0 : ID1)
    ) u_dut (
      .CLK      (clk),
      .RESETn   (rst_n),
      .START    (start[g]),
      .DST_ADDR (dst_addr),
      .BUSY     (busy[g]),
      .DONE     (done[g]),
      .ERR      (err[g]),
      .S_DATA   (s_data),
      .S_VALID  (s_valid),
      .S_READY  (s_ready[g]),
      .AWID     (awid[g]),
      .AWADDR   (awaddr[g]),
      .AWLEN    (awlen[g]),
      .AWSIZE   (awsize[g]),
      .AWBURST  (awburst[g]),
      .AWLOCK   (awlock[g]),
      .AWCACHE  (awcache[g]),
      .AWPROT   (awprot[g]),
      .AWVALID  (awvalid[g]),
      .AWREADY  (awready),
      .WDATA    (wdata[g]),
      .WSTRB    (wstrb[g]),
      .WLAST    (wlast[g]),
      .WVALID   (wvalid[g]),
      .WREADY   (wready),
      .BID      (bid),
      .BRESP    (bresp),
      .BVALID   (bvalid),
      .BREADY   (bready[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int sel     = 0;
  bit stall_en = 1'b0;
  int aw_hold_until = 0;
  int w_cnt = 0;

  logic [39:0] exp_aw   [$];
  logic [64:0] exp_w    [$];
  logic [63:0] stream_q [$];
  logic [1:0]  bresp_q  [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_ctl"}, 64'({busy[d], done[d], err[d], awvalid[d], wvalid[d], wlast[d],
                             bready[d], s_ready[d]}), 64'd0);
      chk({tag, "_aw"}, 64'({awaddr[d], awlen[d]}), 64'd0);
    end
  endtask

  // Build the expected AW/W traffic, load the stream, pulse START, check cycle 1.
  task automatic issue_job(input int d, input logic [31:0] addr, input int nw, input int job,
                           input bit stall, input int awblk, output int lat_exp, output int c0);
    int rem, b, k;
    logic [31:0] a;
    logic [63:0] word;
    bit mis;
    mis = (addr[2:0] != 3'b000);
    sel = d;
    stall_en = stall;
    bid = (d == 0) ? ID0 : ID1;
    lat_exp = 2;
    rem = mis ? 0 : nw;
    a = addr;
    k = 0;
    while (rem > 0) begin
      b = (rem > BL) ? BL : rem;
      exp_aw.push_back({a, 8'(b - 1)});
      for (int i = 0; i < b; i++) begin
        word = {32'(job), 32'(k + 1)};
        stream_q.push_back(word);
        exp_w.push_back({word, (i == b - 1)});
        k++;
      end
      lat_exp += 2 + b;
      a += 32'(8 * b);
      rem -= b;
    end
    @(posedge clk); #1;
    dst_addr = addr;
    start[d] = 1'b1;
    c0 = cyc;
    aw_hold_until = cyc + awblk;
    @(posedge clk); #1;
    start[d] = 1'b0;
    @(negedge clk);
    chk("busy_after_start", 64'(busy[d]), 64'd1);
    chk("err_after_start", 64'(err[d]), 64'(mis));
  endtask

  task automatic wait_done(input int d, input int lat_exp, input int c0, input bit chk_lat,
                           input bit exp_err);
    bit seen = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (done[d]) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      chk("done_timeout", 64'd0, 64'd1);
    end else begin
      if (chk_lat) chk("done_latency", 64'(cyc - c0), 64'(lat_exp));
      chk("err_at_done", 64'(err[d]), 64'(exp_err));
      chk("busy_at_done", 64'(busy[d]), 64'd1);
      chk("aw_left", 64'(exp_aw.size()), 64'd0);
      chk("w_left", 64'(exp_w.size()), 64'd0);
      @(negedge clk);
      chk("done_pulse", 64'({done[d], busy[d]}), 64'd0);
    end
  endtask

  // Slave model and monitor: sample at negedge, update inputs 1 ns after posedge.
  bit          aw_stall_pend, in_burst, b_pend, s_pop, b_done;
  logic [39:0] aw_snap, e_aw;
  logic [64:0] e_w;
  logic [3:0]  exp_id;
  initial begin
    s_valid = 1'b0; s_data = '0; awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_aw.delete(); exp_w.delete(); stream_q.delete(); bresp_q.delete();
        aw_stall_pend = 1'b0; in_burst = 1'b0; b_pend = 1'b0; s_pop = 1'b0; b_done = 1'b0;
      end else begin
        if (!in_burst) chk("w_outside_burst", 64'({wvalid[sel], s_ready[sel]}), 64'd0);
        if (aw_stall_pend)
          chk("aw_stable", 64'({awvalid[sel], awaddr[sel], awlen[sel]}), 64'({1'b1, aw_snap}));
        aw_stall_pend = awvalid[sel] && !awready;
        aw_snap = {awaddr[sel], awlen[sel]};
        if (awvalid[sel] && awready) begin
          exp_id = (sel == 0) ? ID0 : ID1;
          if (exp_aw.size() == 0) begin
            chk("aw_unexpected", 64'd1, 64'd0);
          end else begin
            e_aw = exp_aw.pop_front();
            chk("awaddr", 64'(awaddr[sel]), 64'(e_aw[39:8]));
            chk("awlen", 64'(awlen[sel]), 64'(e_aw[7:0]));
          end
          chk("aw_fields", 64'({awid[sel], awsize[sel], awburst[sel], awlock[sel], awcache[sel],
                               awprot[sel]}), 64'({exp_id, 3'd3, 2'b01, 1'b0, 4'd0, 3'd0}));
          in_burst = 1'b1;
        end
        if (wvalid[sel] && wready) begin
          w_cnt++;
          if (exp_w.size() == 0) begin
            chk("w_unexpected", 64'd1, 64'd0);
          end else begin
            e_w = exp_w.pop_front();
            chk("wdata", wdata[sel], e_w[64:1]);
            chk("wlast", 64'(wlast[sel]), 64'(e_w[0]));
            chk("wstrb", 64'(wstrb[sel]), 64'hFF);
            if (e_w[0]) begin
              in_burst = 1'b0;
              b_pend = 1'b1;
            end
          end
        end
        s_pop  = s_valid && s_ready[sel];
        b_done = bvalid && bready[sel];
      end
      @(posedge clk); #1;
      if (s_pop && stream_q.size() > 0) void'(stream_q.pop_front());
      s_valid = (stream_q.size() > 0) && (!stall_en || ($urandom_range(0, 1) == 1));
      s_data  = (stream_q.size() > 0) ? stream_q[0] : 64'd0;
      wready  = !stall_en || ($urandom_range(0, 1) == 1);
      awready = (cyc >= aw_hold_until);
      if (!rst_n || b_done) bvalid = 1'b0;
      if (rst_n && b_pend && !bvalid) begin
        bvalid = 1'b1;
        bresp = 2'b00;
        if (bresp_q.size() > 0) bresp = bresp_q.pop_front();
        b_pend = 1'b0;
      end
      s_pop = 1'b0;
      b_done = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, c0, w0;
    rst_n = 1'b0; start = '0; dst_addr = '0; bid = ID0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("rst_init");
    #2 rst_n = 1'b1;

    issue_job(0, 32'h0000_0100, 4, 0, 1'b0, 0, lat, c0);
    wait_done(0, lat, c0, 1'b1, 1'b0);

    issue_job(1, 32'h0000_1000, 20, 1, 1'b0, 0, lat, c0);
    wait_done(1, lat, c0, 1'b1, 1'b0);

    issue_job(1, 32'h0000_2000, 20, 2, 1'b1, 6, lat, c0);
    wait_done(1, lat, c0, 1'b0, 1'b0);

    bresp_q.push_back(2'b10);
    issue_job(1, 32'h0000_3000, 20, 3, 1'b0, 0, lat, c0);
    wait_done(1, lat, c0, 1'b1, 1'b1);

    issue_job(1, 32'h0000_3000, 20, 4, 1'b0, 0, lat, c0);
    wait_done(1, lat, c0, 1'b1, 1'b0);

    issue_job(0, 32'h0000_0104, 4, 5, 1'b0, 0, lat, c0);
    wait_done(0, lat, c0, 1'b1, 1'b1);

    issue_job(1, 32'h0000_5000, 20, 6, 1'b0, 0, lat, c0);
    w0 = w_cnt;
    for (int n = 0; n < 100 && w_cnt < w0 + 3; n++) @(negedge clk);
    #1;
    chk("rst_mid_in_w", 64'(wvalid[1]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_state("rst_mid");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    issue_job(1, 32'h0000_6000, 20, 7, 1'b0, 0, lat, c0);
    wait_done(1, lat, c0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
